// File: rtl/ahb2apb_pkg.sv
// Shared definitions for the AHB-to-APB bridge: widths, APB controller
// state encoding and the bus values driven while no transfer is active.
package ahb2apb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int SEL_W  = 3;

    // APB controller states. WWAIT covers the cycle where a write address
    // has been accepted but its data is not yet registered.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WWAIT    = 3'd1,
        ST_READ     = 3'd2,
        ST_WRITE    = 3'd3,
        ST_WRITEP   = 3'd4,
        ST_RENABLE  = 3'd5,
        ST_WENABLE  = 3'd6,
        ST_WENABLEP = 3'd7
    } apb_state_e;

    // Bus control values while the APB is idle (no slave selected).
    localparam logic [SEL_W-1:0] IDLE_PSEL    = 3'b000;
    localparam logic             IDLE_PENABLE = 1'b0;

endpackage : ahb2apb_pkg

// File: rtl/apb_controller.sv
// APB phase sequencer of the AHB-to-APB bridge. Every transfer is an APB
// setup cycle followed by an enable cycle; back-to-back writes alternate
// WRITEP/WENABLEP without returning to IDLE. All bus outputs are registered
// and computed from the next state, so they line up with the state they
// belong to.
module apb_controller #(
    parameter int ADDR_W = ahb2apb_pkg::ADDR_W,
    parameter int DATA_W = ahb2apb_pkg::DATA_W,
    parameter int SEL_W  = ahb2apb_pkg::SEL_W
) (
    input  logic              hclk,
    input  logic              hreset,
    input  logic              valid,
    input  logic              hwrite,
    input  logic              hwrite_reg,
    input  logic [ADDR_W-1:0] haddr_reg1,
    input  logic [ADDR_W-1:0] haddr_reg2,
    input  logic [DATA_W-1:0] hwdata_reg,
    input  logic [SEL_W-1:0]  tempsel,
    input  logic [DATA_W-1:0] prdata,
    output logic              pwrite,
    output logic              penable,
    output logic [SEL_W-1:0]  psel,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    output logic              hreadyout,
    output logic [DATA_W-1:0] hrdata
);

    import ahb2apb_pkg::*;

    apb_state_e        state_r;
    apb_state_e        next_state_s;

    logic              pwrite_s;
    logic              penable_s;
    logic [SEL_W-1:0]  psel_s;
    logic [ADDR_W-1:0] paddr_s;
    logic [DATA_W-1:0] pwdata_s;
    logic              hreadyout_s;

    // Read data passes straight through to the AHB side.
    assign hrdata = prdata;

    // State register; reset abandons any transfer in flight.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE, ST_RENABLE, ST_WENABLE: begin
                if (valid && !hwrite) begin
                    next_state_s = ST_READ;
                end else if (valid && hwrite) begin
                    next_state_s = ST_WWAIT;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_WWAIT: begin
                if (valid) begin
                    next_state_s = ST_WRITEP;
                end else begin
                    next_state_s = ST_WRITE;
                end
            end
            ST_READ:   next_state_s = ST_RENABLE;
            ST_WRITE:  next_state_s = ST_WENABLE;
            ST_WRITEP: next_state_s = ST_WENABLEP;
            ST_WENABLEP: begin
                if (!hwrite_reg) begin
                    next_state_s = ST_READ;
                end else if (valid) begin
                    next_state_s = ST_WRITEP;
                end else begin
                    next_state_s = ST_WRITE;
                end
            end
            default:   next_state_s = ST_IDLE;
        endcase
    end

    // Next bus values from the next state; address/select are captured only
    // on entry to a setup state so enable cycles ignore input changes.
    always_comb begin
        psel_s      = psel;
        paddr_s     = paddr;
        pwdata_s    = pwdata;
        pwrite_s    = pwrite;
        penable_s   = penable;
        hreadyout_s = 1'b1;
        case (next_state_s)
            ST_IDLE: begin
                psel_s      = SEL_W'(IDLE_PSEL);
                penable_s   = IDLE_PENABLE;
                hreadyout_s = 1'b1;
            end
            ST_WWAIT: begin
                psel_s    = SEL_W'(IDLE_PSEL);
                penable_s = IDLE_PENABLE;
                // Arriving straight from an enable cycle the master has already
                // moved on, so hold it until the write data is registered.
                if (state_r == ST_IDLE) begin
                    hreadyout_s = 1'b1;
                end else begin
                    hreadyout_s = 1'b0;
                end
            end
            ST_READ: begin
                psel_s      = tempsel;
                paddr_s     = haddr_reg1;
                pwrite_s    = 1'b0;
                penable_s   = 1'b0;
                hreadyout_s = 1'b0;
            end
            ST_WRITE: begin
                psel_s      = tempsel;
                paddr_s     = haddr_reg1;
                pwdata_s    = hwdata_reg;
                pwrite_s    = 1'b1;
                penable_s   = 1'b0;
                hreadyout_s = 1'b0;
            end
            ST_WRITEP: begin
                // The newer address is still in its AHB address phase, so the
                // one belonging to this data is two registers back.
                psel_s      = tempsel;
                paddr_s     = haddr_reg2;
                pwdata_s    = hwdata_reg;
                pwrite_s    = 1'b1;
                penable_s   = 1'b0;
                hreadyout_s = 1'b0;
            end
            ST_RENABLE, ST_WENABLE, ST_WENABLEP: begin
                penable_s   = 1'b1;
                hreadyout_s = 1'b1;
            end
            default: begin
                psel_s      = SEL_W'(IDLE_PSEL);
                penable_s   = IDLE_PENABLE;
                hreadyout_s = 1'b1;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            pwrite    <= 1'b0;
            penable   <= 1'b0;
            psel      <= {SEL_W{1'b0}};
            paddr     <= {ADDR_W{1'b0}};
            pwdata    <= {DATA_W{1'b0}};
            hreadyout <= 1'b1;
        end else begin
            pwrite    <= pwrite_s;
            penable   <= penable_s;
            psel      <= psel_s;
            paddr     <= paddr_s;
            pwdata    <= pwdata_s;
            hreadyout <= hreadyout_s;
        end
    end

endmodule : apb_controller

// File: tb/tb_apb_controller.sv
// Bench for apb_controller: directed transfers push the expected APB enable
// cycles into a queue; a monitor pops and compares on every enable cycle and
// also checks setup/enable pairing invariants.
module tb_apb_controller;

    typedef struct packed {
        logic [2:0]  sel;
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } xfer_t;

    logic        hclk;
    logic        hreset;
    logic        valid;
    logic        hwrite;
    logic        hwrite_reg;
    logic [31:0] haddr_reg1;
    logic [31:0] haddr_reg2;
    logic [31:0] hwdata_reg;
    logic [2:0]  tempsel;
    logic [31:0] prdata;
    logic        pwrite;
    logic        penable;
    logic [2:0]  psel;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        hreadyout;
    logic [31:0] hrdata;

    int    total = 0;
    int    bad   = 0;
    bit    sb_en = 1'b1;
    xfer_t q[$];

    localparam logic [31:0] PRD = 32'h1234_5678;

    apb_controller #(.ADDR_W(32), .DATA_W(32), .SEL_W(3)) dut (
        .hclk(hclk), .hreset(hreset), .valid(valid), .hwrite(hwrite),
        .hwrite_reg(hwrite_reg), .haddr_reg1(haddr_reg1), .haddr_reg2(haddr_reg2),
        .hwdata_reg(hwdata_reg), .tempsel(tempsel), .prdata(prdata),
        .pwrite(pwrite), .penable(penable), .psel(psel), .paddr(paddr),
        .pwdata(pwdata), .hreadyout(hreadyout), .hrdata(hrdata)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs, then return just after the clock edge.
    task automatic drive(input logic v, input logic hw, input logic hwr,
                         input logic [31:0] a1, input logic [31:0] a2,
                         input logic [31:0] wd, input logic [2:0] sel);
        valid = v; hwrite = hw; hwrite_reg = hwr;
        haddr_reg1 = a1; haddr_reg2 = a2; hwdata_reg = wd; tempsel = sel;
        @(posedge hclk);
        #1;
    endtask

    task automatic push(input logic [2:0] sel, input logic [31:0] addr,
                        input logic wr, input logic [31:0] wd);
        xfer_t x;
        x.sel = sel; x.addr = addr; x.wr = wr; x.wdata = wd; x.rdata = PRD;
        q.push_back(x);
    endtask

    // Monitor: every enable cycle must follow a matching setup cycle and
    // match the next queued transfer.
    initial begin
        logic        prev_pen;
        logic        prev_hr;
        logic [2:0]  prev_sel;
        logic [31:0] prev_addr;
        xfer_t       e;
        prev_pen = 1'b0; prev_hr = 1'b1; prev_sel = 3'b000; prev_addr = 32'h0;
        forever begin
            @(negedge hclk);
            if (penable === 1'b1) begin
                chk("penable_back_to_back", {63'd0, prev_pen}, 64'd0);
                chk("psel_setup_to_enable", {61'd0, psel}, {61'd0, prev_sel});
                chk("paddr_setup_to_enable", {32'd0, paddr}, {32'd0, prev_addr});
                chk("hready_low_in_setup", {63'd0, prev_hr}, 64'd0);
                chk("hready_high_in_enable", {63'd0, hreadyout}, 64'd1);
                if (sb_en) begin
                    if (q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_enable: got addr %h with none expected", paddr);
                    end else begin
                        e = q.pop_front();
                        chk("sb_psel", {61'd0, psel}, {61'd0, e.sel});
                        chk("sb_paddr", {32'd0, paddr}, {32'd0, e.addr});
                        chk("sb_pwrite", {63'd0, pwrite}, {63'd0, e.wr});
                        chk("sb_pwdata", {32'd0, pwdata}, {32'd0, e.wdata});
                        chk("sb_hrdata", {32'd0, hrdata}, {32'd0, e.rdata});
                    end
                end
            end
            prev_pen = penable; prev_hr = hreadyout; prev_sel = psel; prev_addr = paddr;
        end
    end

    initial begin
        prdata = PRD;
        hreset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 3'b000);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 3'b000);
        chk("rst_pwrite", {63'd0, pwrite}, 64'd0);
        chk("rst_penable", {63'd0, penable}, 64'd0);
        chk("rst_psel", {61'd0, psel}, 64'd0);
        chk("rst_paddr", {32'd0, paddr}, 64'd0);
        chk("rst_pwdata", {32'd0, pwdata}, 64'd0);
        chk("rst_hready", {63'd0, hreadyout}, 64'd1);
        hreset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 3'b000);

        // Single read
        push(3'b001, 32'h8000_0010, 1'b0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h8000_0010, 32'h0, 32'h0, 3'b001);
        chk("rd_setup_psel", {61'd0, psel}, 64'd1);
        chk("rd_setup_paddr", {32'd0, paddr}, 64'h8000_0010);
        chk("rd_setup_penable", {63'd0, penable}, 64'd0);
        chk("rd_setup_hready", {63'd0, hreadyout}, 64'd0);
        drive(1'b0, 1'b0, 1'b0, 32'h8000_0010, 32'h0, 32'h0, 3'b001);
        chk("rd_enable", {63'd0, penable}, 64'd1);
        drive(1'b0, 1'b0, 1'b0, 32'h8000_0010, 32'h0, 32'h0, 3'b001);
        chk("rd_idle_psel", {61'd0, psel}, 64'd0);

        // Single write
        push(3'b010, 32'h8400_0004, 1'b1, 32'hDEAD_BEEF);
        drive(1'b1, 1'b1, 1'b0, 32'h8400_0004, 32'h0, 32'hDEAD_BEEF, 3'b010);
        chk("wr_wwait_psel", {61'd0, psel}, 64'd0);
        chk("wr_wwait_hready", {63'd0, hreadyout}, 64'd1);
        drive(1'b0, 1'b0, 1'b1, 32'h8400_0004, 32'h0, 32'hDEAD_BEEF, 3'b010);
        chk("wr_setup_pwrite", {63'd0, pwrite}, 64'd1);
        chk("wr_setup_hready", {63'd0, hreadyout}, 64'd0);
        drive(1'b0, 1'b0, 1'b1, 32'h8400_0004, 32'h0, 32'hDEAD_BEEF, 3'b010);
        drive(1'b0, 1'b0, 1'b0, 32'h8400_0004, 32'h0, 32'hDEAD_BEEF, 3'b010);
        chk("wr_idle_penable", {63'd0, penable}, 64'd0);
        chk("wr_idle_paddr_hold", {32'd0, paddr}, 64'h8400_0004);

        // Pipelined writes
        push(3'b100, 32'h8000_0000, 1'b1, 32'h1111_0000);
        push(3'b100, 32'h8000_0004, 1'b1, 32'h2222_0004);
        push(3'b100, 32'h8000_0008, 1'b1, 32'h3333_0008);
        drive(1'b1, 1'b1, 1'b0, 32'h8000_0000, 32'h0,         32'h0,         3'b100);
        drive(1'b1, 1'b1, 1'b1, 32'h8000_0004, 32'h8000_0000, 32'h1111_0000, 3'b100);
        chk("pw_writep_paddr", {32'd0, paddr}, 64'h8000_0000);
        chk("pw_writep_hready", {63'd0, hreadyout}, 64'd0);
        drive(1'b1, 1'b1, 1'b1, 32'h8000_0008, 32'h8000_0004, 32'h2222_0004, 3'b100);
        drive(1'b1, 1'b1, 1'b1, 32'h8000_0008, 32'h8000_0004, 32'h2222_0004, 3'b100);
        chk("pw_writep2_paddr", {32'd0, paddr}, 64'h8000_0004);
        drive(1'b0, 1'b0, 1'b1, 32'h8000_0008, 32'h8000_0004, 32'h3333_0008, 3'b100);
        drive(1'b0, 1'b0, 1'b1, 32'h8000_0008, 32'h8000_0004, 32'h3333_0008, 3'b100);
        chk("pw_write_paddr", {32'd0, paddr}, 64'h8000_0008);
        drive(1'b0, 1'b0, 1'b0, 32'h8000_0008, 32'h8000_0004, 32'h3333_0008, 3'b100);
        drive(1'b0, 1'b0, 1'b0, 32'h8000_0008, 32'h8000_0004, 32'h3333_0008, 3'b100);

        // Write then read, then a write from the read enable
        push(3'b001, 32'h8000_0020, 1'b1, 32'h4444_0020);
        push(3'b010, 32'h8000_0030, 1'b0, 32'h4444_0020);
        push(3'b100, 32'h8000_0040, 1'b1, 32'hCAFE_F00D);
        drive(1'b1, 1'b1, 1'b0, 32'h8000_0020, 32'h0,         32'h0,         3'b001);
        drive(1'b1, 1'b0, 1'b1, 32'h8000_0030, 32'h8000_0020, 32'h4444_0020, 3'b001);
        drive(1'b1, 1'b0, 1'b1, 32'h8000_0030, 32'h8000_0020, 32'h4444_0020, 3'b001);
        drive(1'b0, 1'b0, 1'b0, 32'h8000_0030, 32'h8000_0020, 32'h4444_0020, 3'b010);
        chk("wr_rd_direct_psel", {61'd0, psel}, 64'd2);
        chk("wr_rd_direct_pwrite", {63'd0, pwrite}, 64'd0);
        chk("wr_rd_direct_penable", {63'd0, penable}, 64'd0);
        drive(1'b0, 1'b0, 1'b0, 32'h8000_0030, 32'h8000_0020, 32'h4444_0020, 3'b010);
        drive(1'b1, 1'b1, 1'b0, 32'h8000_0030, 32'h8000_0020, 32'h4444_0020, 3'b010);
        chk("wwait_from_enable_hready", {63'd0, hreadyout}, 64'd0);
        chk("wwait_from_enable_psel", {61'd0, psel}, 64'd0);
        drive(1'b0, 1'b0, 1'b1, 32'h8000_0040, 32'h0, 32'hCAFE_F00D, 3'b100);
        drive(1'b0, 1'b0, 1'b1, 32'h8000_0040, 32'h0, 32'hCAFE_F00D, 3'b100);
        drive(1'b0, 1'b0, 1'b0, 32'h8000_0040, 32'h0, 32'hCAFE_F00D, 3'b100);

        // Reset during a write setup: no enable cycle may follow
        drive(1'b1, 1'b1, 1'b0, 32'h8000_0050, 32'h0, 32'h5555_5555, 3'b001);
        drive(1'b0, 1'b0, 1'b1, 32'h8000_0050, 32'h0, 32'h5555_5555, 3'b001);
        hreset = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 32'h8000_0050, 32'h0, 32'h5555_5555, 3'b001);
        hreset = 1'b0;
        chk("abort_setup_psel", {61'd0, psel}, 64'd0);
        drive(1'b0, 1'b0, 1'b0, 32'h8000_0050, 32'h0, 32'h5555_5555, 3'b001);
        chk("abort_setup_no_enable", {63'd0, penable}, 64'd0);

        // Reset during WENABLE
        push(3'b010, 32'h8000_0060, 1'b1, 32'h6666_6666);
        drive(1'b1, 1'b1, 1'b0, 32'h8000_0060, 32'h0, 32'h6666_6666, 3'b010);
        drive(1'b0, 1'b0, 1'b1, 32'h8000_0060, 32'h0, 32'h6666_6666, 3'b010);
        drive(1'b0, 1'b0, 1'b1, 32'h8000_0060, 32'h0, 32'h6666_6666, 3'b010);
        chk("wenable_before_reset", {63'd0, penable}, 64'd1);
        hreset = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 32'h8000_0070, 32'h0, 32'h6666_6666, 3'b010);
        hreset = 1'b0;
        chk("rst_mid_penable", {63'd0, penable}, 64'd0);
        chk("rst_mid_psel", {61'd0, psel}, 64'd0);
        chk("rst_mid_hready", {63'd0, hreadyout}, 64'd1);
        chk("rst_mid_paddr", {32'd0, paddr}, 64'd0);
        chk("rst_mid_pwdata", {32'd0, pwdata}, 64'd0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 3'b000);
        chk("rst_mid_idle_penable", {63'd0, penable}, 64'd0);
        chk("sb_drain_directed", 64'(q.size()), 64'd0);

        // Random traffic: only the setup/enable invariants are checked
        sb_en = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            logic [2:0] rsel;
            rsel = 3'b001 << $urandom_range(2, 0);
            drive(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                  32'($urandom), 32'($urandom), 32'($urandom), rsel);
        end
        hreset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 3'b000);
        hreset = 1'b0;
        chk("final_reset_hready", {63'd0, hreadyout}, 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_apb_controller

// File: doc/apb_controller.md
# apb_controller

- Drives the APB bus phases of the AHB-to-APB bridge.
- Sits between the AHB slave interface (registered address/data/control, `valid`, decoded slave select) and `apb_interface`, which receives its `pwrite`, `penable`, `psel`, `paddr` and `pwdata` outputs.
- Sequences every transfer as an APB setup cycle followed by an enable cycle, handling single reads, single writes and back-to-back pipelined writes.
- Generates `hreadyout` to stall the AHB master while an APB transfer is in its setup phase.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- SEL_W, 3, slave-select width

Ports:
- hclk  in  1  bridge clock; all state changes on rising edge
- hreset  in  1  synchronous active-high reset
- valid  in  1  AHB slave interface has a valid transfer to the APB address range this cycle
- hwrite  in  1  direction of the current AHB address-phase transfer (1 = write)
- hwrite_reg  in  1  direction of the transfer registered one cycle earlier
- haddr_reg1  in  ADDR_W  address registered one cycle earlier
- haddr_reg2  in  ADDR_W  address registered two cycles earlier
- hwdata_reg  in  DATA_W  registered AHB write data
- tempsel  in  SEL_W  one-hot decoded slave select
- prdata  in  DATA_W  read data returned by `apb_interface`
- pwrite  out  1  APB direction
- penable  out  1  APB enable phase
- psel  out  SEL_W  APB slave select
- paddr  out  ADDR_W  APB address
- pwdata  out  DATA_W  APB write data
- hreadyout  out  1  AHB ready; 0 stalls the master
- hrdata  out  DATA_W  AHB read data, combinational copy of `prdata`

## Operation
States: IDLE, WWAIT, READ, WRITE, WRITEP, RENABLE, WENABLE, WENABLEP.

Transitions:
- IDLE:
  - `valid & !hwrite` goes to READ.
  - `valid & hwrite` goes to WWAIT.
  - Otherwise stays in IDLE.
- WWAIT (write data not yet registered):
  - `valid` goes to WRITEP.
  - Otherwise goes to WRITE.
- READ always goes to RENABLE.
- WRITE always goes to WENABLE.
- WRITEP always goes to WENABLEP.
- RENABLE and WENABLE:
  - `valid & !hwrite` goes to READ.
  - `valid & hwrite` goes to WWAIT.
  - Otherwise goes to IDLE.
- WENABLEP:
  - `!hwrite_reg` goes to READ.
  - `hwrite_reg & valid` goes to WRITEP.
  - `hwrite_reg & !valid` goes to WRITE.

Output values:
- READ (setup): `psel`=`tempsel`, `paddr`=`haddr_reg1`, `pwrite`=0, `penable`=0.
- WRITE (setup): `psel`=`tempsel`, `paddr`=`haddr_reg1`, `pwdata`=`hwdata_reg`, `pwrite`=1, `penable`=0.
- WRITEP (setup): as WRITE but `paddr`=`haddr_reg2`; the newer address is still in its AHB address phase.
- RENABLE, WENABLE, WENABLEP: `penable`=1; `psel`, `paddr`, `pwrite`, `pwdata` hold their setup values.
- IDLE and WWAIT: `psel`=0, `penable`=0. `paddr`, `pwdata` and `pwrite` hold their last values.

Register rules:
- All outputs except `hrdata` are registered.
- Their next values are computed from the next state and the current inputs, so output values coincide with the state they belong to.
- `psel` and `paddr` are sampled once, at entry to a setup state.
- Input changes during an enable cycle do not disturb the bus.

## Timing
- Reset (`hreset`=1 at a clock edge):
  - State goes to IDLE.
  - `pwrite`=0, `penable`=0, `psel`=0, `paddr`=0, `pwdata`=0, `hreadyout`=1.
  - Reset overrides any state, including mid-transfer; the aborted transfer is dropped with no enable cycle.
- `hreadyout`:
  - 0 in READ, WRITE and WRITEP, and in WWAIT when entered with `valid`=1 in the same cycle as the previous enable.
  - 1 in IDLE, RENABLE, WENABLE and WENABLEP.
- Single read: IDLE to READ to RENABLE. Setup at cycle N+1, enable at N+2, `hrdata` valid during N+2.
- Single write: IDLE to WWAIT to WRITE to WENABLE, so the bus starts one cycle later than a read.
- Back-to-back writes alternate WRITEP and WENABLEP with no IDLE gap.
- `penable` is never 1 on two consecutive cycles. Every enable cycle is immediately preceded by a setup cycle with the same `psel` and `paddr`.
- `valid` arriving while in an enable state is accepted; no transfer is lost.

## Structure
- The shared package `ahb2apb_pkg` holds:
  - the 3-bit state enum;
  - the IDLE output constant (`psel`=0, `penable`=0);
  - the width constants ADDR_W, DATA_W and SEL_W, which are also used by the AHB slave interface and `apb_interface`.
- Single module with no sub-module:
  - one state register block;
  - one combinational next-state block;
  - one combinational next-output block feeding the output registers.

## Test plan
- Reset: assert `hreset` mid-WENABLE. Next cycle `penable`=0, `psel`=0, `hreadyout`=1, state IDLE.
- Single read: `valid`=1, `hwrite`=0, `haddr_reg1`=0x8000_0010, `tempsel`=3'b001. Setup cycle has `psel`=001, `paddr`=0x8000_0010, `penable`=0, `hreadyout`=0. Next cycle `penable`=1, and `hrdata` equals `prdata`.
- Single write: `hwdata_reg`=0xDEAD_BEEF at 0x8400_0004, `valid` low after the address phase. Sequence WWAIT, WRITE, WENABLE with `pwrite`=1 and `pwdata`=0xDEAD_BEEF. Then IDLE.
- Pipelined writes to 0x8000_0000, 0x8000_0004, 0x8000_0008:
  - States WWAIT, WRITEP, WENABLEP, WRITEP, WENABLEP, then WRITE, WENABLE.
  - Three enable cycles on the bus, with addresses in order.
- Write followed by read (`hwrite_reg`=0 in WENABLEP): goes directly to READ, no IDLE cycle.
- Randomized `valid`/`hwrite` over 10k cycles. `penable` never high on two consecutive cycles, and `psel`/`paddr` are stable across each setup-to-enable pair.
